// File: rtl/div_if.sv
// Operand/result bundle between the execute stage and the multi-cycle divider.
// Handshake: the divider accepts a request on a clock edge where start_i=1, annul_i=0
// and it is idle; ready_o is a one-cycle pulse with result_o valid in that same cycle.
interface div_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic                 signed_i;
    logic                 annul_i;
    logic [WIDTH-1:0]     dividend_i;
    logic [WIDTH-1:0]     divisor_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 stall_o;

    modport slave (
        input  start_i, signed_i, annul_i, dividend_i, divisor_i,
        output result_o, ready_o, stall_o
    );

    modport master (
        output start_i, signed_i, annul_i, dividend_i, divisor_i,
        input  result_o, ready_o, stall_o
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, result as
// {remainder, quotient}; stalls the pipeline while busy, abortable by annul_i.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_if.slave       div_io,
    output logic [1:0] state_o
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               stall;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     rem_shift;
    logic               no_borrow;
    logic [WIDTH-1:0]   rem_step, quo_step;

    // Magnitudes are divided unsigned; signs are reapplied when the result is captured.
    assign a_neg = div_io.signed_i & div_io.dividend_i[WIDTH-1];
    assign b_neg = div_io.signed_i & div_io.divisor_i[WIDTH-1];
    assign a_abs = a_neg ? -div_io.dividend_i : div_io.dividend_i;
    assign b_abs = b_neg ? -div_io.divisor_i  : div_io.divisor_i;

    // The partial remainder is always below the divisor, so the restored value fits WIDTH bits.
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign no_borrow = rem_shift >= {1'b0, dvsr_q};
    assign rem_step  = no_borrow ? (rem_shift[WIDTH-1:0] - dvsr_q) : rem_shift[WIDTH-1:0];
    assign quo_step  = {quo_q[WIDTH-2:0], no_borrow};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        stall     = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = div_io.start_i & ~div_io.annul_i;
                if (div_io.start_i && !div_io.annul_i) begin
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dvsr_d    = b_abs;
                    rem_d     = '0;
                    quo_d     = a_abs;
                    if (div_io.divisor_i == '0) begin
                        state_d  = S_DONE;
                        result_d = {div_io.dividend_i, {WIDTH{1'b1}}};
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = CW'(WIDTH);
                    end
                end
            end
            S_BUSY: begin
                stall = ~div_io.annul_i;
                if (div_io.annul_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d  = S_DONE;
                        result_d = {neg_rem_q ? -rem_step : rem_step,
                                    neg_quo_q ? -quo_step : quo_step};
                    end
                end
            end
            S_DONE: begin
                // A start_i still held here belongs to the finished instruction.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign div_io.result_o = result_q;
    assign div_io.ready_o  = (state_q == S_DONE);
    assign div_io.stall_o  = stall;
    assign state_o         = state_q;
endmodule

// File: tb/tb_div_unit.sv
// Randomised and directed bench for div_unit: expected results are queued at issue
// and a monitor compares them whenever ready_o pulses.
module tb_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] state;

    always #5 clk = ~clk;

    div_if #(.WIDTH(W)) bus();

    div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .div_io  (bus),
        .state_o (state)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: plain integer division; SV division truncates toward zero and
    // the remainder follows the dividend sign, which is the required signed behaviour.
    function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!sg) begin
            uq = a / b;
            ur = a % b;
            return {ur, uq};
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.ready_o) begin
            if (exp_q.size() == 0)
                chk("spurious_ready", {63'd0, bus.ready_o}, 64'd0);
            else
                chk("result", bus.result_o, exp_q.pop_front());
        end
    end

    // Issues one operation starting now (just after a falling edge). Returns at the
    // falling edge after ready with start_i still high, or after an annul.
    task automatic run_op(input bit sg, input logic [31:0] a, input logic [31:0] b, input int annul_at);
        int cyc;
        int lat_exp;
        bus.start_i    = 1'b1;
        bus.signed_i   = sg;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        bus.annul_i    = 1'b0;
        if (annul_at < 0) exp_q.push_back(model(sg, a, b));
        lat_exp = (b == 32'd0) ? 1 : W + 1;
        #1 chk("stall_accept", {63'd0, bus.stall_o}, 64'd1);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.dividend_i = $urandom;
            bus.divisor_i  = $urandom;
            if (cyc == annul_at) begin
                bus.annul_i = 1'b1;
                #1 chk("stall_annul", {63'd0, bus.stall_o}, 64'd0);
                @(negedge clk);
                bus.annul_i = 1'b0;
                bus.start_i = 1'b0;
                #1;
                chk("state_after_annul", {62'd0, state}, 64'd0);
                chk("ready_after_annul", {63'd0, bus.ready_o}, 64'd0);
                return;
            end
            #1;
            if (bus.ready_o || cyc >= 40) break;
            chk("stall_busy", {63'd0, bus.stall_o}, 64'd1);
        end
        chk("latency", 64'(cyc), 64'(lat_exp));
        chk("stall_done", {63'd0, bus.stall_o}, 64'd0);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sg;
        logic [31:0] a, b;
        rst            = 1'b1;
        bus.start_i    = 1'b0;
        bus.signed_i   = 1'b0;
        bus.annul_i    = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", {62'd0, state}, 64'd0);
        chk("reset_result", bus.result_o, 64'd0);
        chk("reset_ready", {63'd0, bus.ready_o}, 64'd0);
        chk("reset_stall", {63'd0, bus.stall_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(1'b0, 32'd100, 32'd7, -1);
        idle();
        chk("result_hold", bus.result_o, {32'd2, 32'd14});
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, -1);
        idle();
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, -1);
        idle();
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        idle();
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        idle();
        run_op(1'b0, 32'd5, 32'd0, -1);
        idle();
        run_op(1'b1, 32'hFFFF_FFF0, 32'd0, -1);
        idle();

        // Annulled operation followed directly by a fresh one.
        run_op(1'b0, 32'd100, 32'd7, 10);
        run_op(1'b0, 32'd9, 32'd3, -1);
        // Back-to-back: next start issued in the first idle cycle after DONE.
        run_op(1'b0, 32'd1000, 32'd33, -1);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1);
        idle();
        idle();

        // Asynchronous reset in the middle of a division.
        bus.start_i    = 1'b1;
        bus.signed_i   = 1'b0;
        bus.dividend_i = 32'd12345;
        bus.divisor_i  = 32'd17;
        repeat (5) @(negedge clk);
        bus.start_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("midreset_state", {62'd0, state}, 64'd0);
        chk("midreset_ready", {63'd0, bus.ready_o}, 64'd0);
        chk("midreset_stall", {63'd0, bus.stall_o}, 64'd0);
        chk("midreset_result", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if (i % 4 == 3) a = 32'($urandom_range(0, 1000));
            run_op(sg, a, b, -1);
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();
        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
